// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS32 control unit: FSM states,
// opcode/funct values and the ALU operation codes the ALU also decodes.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH        = 4'd0,
        DECODE       = 4'd1,
        MEM_ADDR     = 4'd2,
        MEM_READ     = 4'd3,
        MEM_WB       = 4'd4,
        MEM_WRITE    = 4'd5,
        EXECUTE      = 4'd6,
        R_COMPLETION = 4'd7,
        BRANCH       = 4'd8,
        JUMP         = 4'd9,
        ADDI_EXEC    = 4'd10,
        ADDI_WB      = 4'd11
    } estado_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    function automatic logic opcode_valido(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/decod_alu.sv
// R-type funct decoder: ALU operation code plus a flag for supported functs.
module decod_alu
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl,
    output logic       funct_valido
);

    always_comb begin
        alu_ctl      = ALU_AND;
        funct_valido = 1'b1;
        case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_NOR:  alu_ctl = ALU_NOR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: funct_valido = 1'b0;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS32 control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects, write enables and ALU operation.
//
// state        | meaning
// FETCH        | read instruction at PC, PC+4 (load IR/PC once memory ready)
// DECODE       | compute branch target, dispatch on opcode/funct
// MEM_ADDR     | ALUOut = A + signext (lw/sw address)
// MEM_READ     | read data memory into MDR, wait for memory
// MEM_WB       | write MDR into rt
// MEM_WRITE    | write B to data memory, wait for memory
// EXECUTE      | R-type ALU operation on A, B
// R_COMPLETION | write ALUOut into rd
// BRANCH       | compare A, B; load branch target if Zero
// JUMP         | load jump target
// ADDI_EXEC    | ALUOut = A + signext
// ADDI_WB      | write ALUOut into rt
module controle_multiciclo
    import mips_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       MemPronto,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUcontrol,
    output logic       invalido,
    output logic [3:0] estado
);

    estado_t    state;
    logic [3:0] alu_funct;
    logic       funct_valido;
    logic       dec_invalido;

    decod_alu u_decod_alu (
        .funct        (funct),
        .alu_ctl      (alu_funct),
        .funct_valido (funct_valido)
    );

    assign dec_invalido = !opcode_valido(opcode) ||
                          ((opcode == OP_RTYPE) && !funct_valido);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:        if (MemPronto) state <= DECODE;
                DECODE: begin
                    if (dec_invalido)
                        state <= FETCH;
                    else begin
                        case (opcode)
                            OP_LW, OP_SW: state <= MEM_ADDR;
                            OP_RTYPE:     state <= EXECUTE;
                            OP_BEQ:       state <= BRANCH;
                            OP_J:         state <= JUMP;
                            OP_ADDI:      state <= ADDI_EXEC;
                            default:      state <= FETCH;
                        endcase
                    end
                end
                MEM_ADDR:     state <= (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
                MEM_READ:     if (MemPronto) state <= MEM_WB;
                MEM_WB:       state <= FETCH;
                MEM_WRITE:    if (MemPronto) state <= FETCH;
                EXECUTE:      state <= R_COMPLETION;
                R_COMPLETION: state <= FETCH;
                BRANCH:       state <= FETCH;
                JUMP:         state <= FETCH;
                ADDI_EXEC:    state <= ADDI_WB;
                ADDI_WB:      state <= FETCH;
                default:      state <= FETCH;
            endcase
        end
    end

    // Outputs follow the state register; reset forces everything low so no
    // write can escape in the cycle that aborts an instruction.
    always_comb begin
        PCEn       = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        ALUcontrol = ALU_AND;
        invalido   = 1'b0;
        estado     = 4'd0;
        if (!reset) begin
            estado = state;
            case (state)
                FETCH: begin
                    MemRead    = 1'b1;
                    ALUSrcB    = 2'b01;
                    ALUcontrol = ALU_ADD;
                    IRWrite    = MemPronto;
                    PCEn       = MemPronto;
                end
                DECODE: begin
                    ALUSrcB    = 2'b11;
                    ALUcontrol = ALU_ADD;
                    invalido   = dec_invalido;
                end
                MEM_ADDR, ADDI_EXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUcontrol = ALU_ADD;
                end
                MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXECUTE: begin
                    ALUSrcA    = 1'b1;
                    ALUcontrol = alu_funct;
                end
                R_COMPLETION: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    ALUcontrol = alu_funct;
                end
                BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUcontrol = ALU_SUB;
                    PCSource   = 2'b01;
                    PCEn       = Zero;
                end
                JUMP: begin
                    PCSource = 2'b10;
                    PCEn     = 1'b1;
                end
                ADDI_WB:  RegWrite = 1'b1;
                default:  invalido = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: per-cycle vector table plus
// hand sequences for cycles-per-instruction and the combinational Zero path.
module tb_controle_multiciclo;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       MemPronto;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUcontrol;
    logic       invalido;
    logic [3:0] estado;

    controle_multiciclo dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .Zero       (Zero),
        .MemPronto  (MemPronto),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .ALUcontrol (ALUcontrol),
        .invalido   (invalido),
        .estado     (estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] estado;
        logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsource;
        logic [3:0] aluctl;
        logic       inv;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       mp;
        outs_t      exp;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    // enable bits: pcen iord memread memwrite irwrite regdst memtoreg regwrite alusrca
    function automatic outs_t mk(input logic [3:0] st, input logic [8:0] en,
                                 input logic [1:0] sb, input logic [1:0] ps,
                                 input logic [3:0] alu, input logic inv);
        outs_t o;
        o.estado = st;
        {o.pcen, o.iord, o.memread, o.memwrite, o.irwrite,
         o.regdst, o.memtoreg, o.regwrite, o.alusrca} = en;
        o.alusrcb  = sb;
        o.pcsource = ps;
        o.aluctl   = alu;
        o.inv      = inv;
        return o;
    endfunction

    function automatic outs_t actual();
        outs_t o;
        o.estado = estado;
        {o.pcen, o.iord, o.memread, o.memwrite, o.irwrite,
         o.regdst, o.memtoreg, o.regwrite, o.alusrca} =
            {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA};
        o.alusrcb  = ALUSrcB;
        o.pcsource = PCSource;
        o.aluctl   = ALUcontrol;
        o.inv      = invalido;
        return o;
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic mp, input outs_t e);
        vec_t t;
        t.rst = r; t.op = op; t.fn = fn; t.z = z; t.mp = mp; t.exp = e;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one instruction from FETCH with memory always ready; returns the
    // cycle count and the number of IRWrite/RegWrite pulses seen.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             output int cyc, output int irw, output int rw, output int done);
        cyc = 0; irw = 0; rw = 0; done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            reset = 1'b0; opcode = op; funct = fn; Zero = 1'b0; MemPronto = 1'b1;
            #1;
            cyc++;
            irw += int'(IRWrite);
            rw  += int'(RegWrite);
            @(posedge clock);
            #1;
            if (estado == 4'd0) begin
                done = 1;
                break;
            end
        end
    endtask

    outs_t RST, F_OK, F_WAIT, DEC, DEC_INV, MADDR, MRD, MWB, MWR, JMP, AEX, AWB;

    function automatic outs_t exe(input logic [3:0] a);
        return mk(4'd6, 9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, a, 1'b0);
    endfunction

    function automatic outs_t rc(input logic [3:0] a);
        return mk(4'd7, 9'b0_0_0_0_0_1_0_1_0, 2'b00, 2'b00, a, 1'b0);
    endfunction

    function automatic outs_t br(input logic z);
        return mk(4'd8, {z, 8'b0_0_0_0_0_0_0_1}, 2'b00, 2'b01, 4'b0110, 1'b0);
    endfunction

    initial begin
        int   cyc, irw, rw, done;
        outs_t a;

        reset = 1'b1; opcode = 6'b0; funct = 6'b0; Zero = 1'b0; MemPronto = 1'b1;

        RST     = '0;
        F_OK    = mk(4'd0,  9'b1_0_1_0_1_0_0_0_0, 2'b01, 2'b00, 4'b0010, 1'b0);
        F_WAIT  = mk(4'd0,  9'b0_0_1_0_0_0_0_0_0, 2'b01, 2'b00, 4'b0010, 1'b0);
        DEC     = mk(4'd1,  9'b0,                 2'b11, 2'b00, 4'b0010, 1'b0);
        DEC_INV = mk(4'd1,  9'b0,                 2'b11, 2'b00, 4'b0010, 1'b1);
        MADDR   = mk(4'd2,  9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 4'b0010, 1'b0);
        MRD     = mk(4'd3,  9'b0_1_1_0_0_0_0_0_0, 2'b00, 2'b00, 4'b0000, 1'b0);
        MWB     = mk(4'd4,  9'b0_0_0_0_0_0_1_1_0, 2'b00, 2'b00, 4'b0000, 1'b0);
        MWR     = mk(4'd5,  9'b0_1_0_1_0_0_0_0_0, 2'b00, 2'b00, 4'b0000, 1'b0);
        JMP     = mk(4'd9,  9'b1_0_0_0_0_0_0_0_0, 2'b00, 2'b10, 4'b0000, 1'b0);
        AEX     = mk(4'd10, 9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 4'b0010, 1'b0);
        AWB     = mk(4'd11, 9'b0_0_0_0_0_0_0_1_0, 2'b00, 2'b00, 4'b0000, 1'b0);

        // reset
        add(1, 6'b100011, 6'b0, 0, 1, RST);
        add(1, 6'b100011, 6'b0, 0, 1, RST);
        // lw, memory ready
        add(0, 6'b100011, 6'b0, 0, 1, F_OK);
        add(0, 6'b100011, 6'b0, 0, 1, DEC);
        add(0, 6'b100011, 6'b0, 0, 1, MADDR);
        add(0, 6'b100011, 6'b0, 0, 1, MRD);
        add(0, 6'b100011, 6'b0, 0, 1, MWB);
        // sw
        add(0, 6'b101011, 6'b0, 0, 1, F_OK);
        add(0, 6'b101011, 6'b0, 0, 1, DEC);
        add(0, 6'b101011, 6'b0, 0, 1, MADDR);
        add(0, 6'b101011, 6'b0, 0, 1, MWR);
        // R-type slt, nor, sub, or
        add(0, 6'b000000, 6'b101010, 0, 1, F_OK);
        add(0, 6'b000000, 6'b101010, 0, 1, DEC);
        add(0, 6'b000000, 6'b101010, 0, 1, exe(4'b0111));
        add(0, 6'b000000, 6'b101010, 0, 1, rc(4'b0111));
        add(0, 6'b000000, 6'b100111, 0, 1, F_OK);
        add(0, 6'b000000, 6'b100111, 0, 1, DEC);
        add(0, 6'b000000, 6'b100111, 0, 1, exe(4'b1100));
        add(0, 6'b000000, 6'b100111, 0, 1, rc(4'b1100));
        add(0, 6'b000000, 6'b100010, 0, 1, F_OK);
        add(0, 6'b000000, 6'b100010, 0, 1, DEC);
        add(0, 6'b000000, 6'b100010, 0, 1, exe(4'b0110));
        add(0, 6'b000000, 6'b100010, 0, 1, rc(4'b0110));
        add(0, 6'b000000, 6'b100101, 0, 1, F_OK);
        add(0, 6'b000000, 6'b100101, 0, 1, DEC);
        add(0, 6'b000000, 6'b100101, 0, 1, exe(4'b0001));
        add(0, 6'b000000, 6'b100101, 0, 1, rc(4'b0001));
        // beq taken / not taken (Zero only matters in BRANCH)
        add(0, 6'b000100, 6'b0, 0, 1, F_OK);
        add(0, 6'b000100, 6'b0, 0, 1, DEC);
        add(0, 6'b000100, 6'b0, 1, 1, br(1'b1));
        add(0, 6'b000100, 6'b0, 1, 1, F_OK);
        add(0, 6'b000100, 6'b0, 1, 1, DEC);
        add(0, 6'b000100, 6'b0, 0, 1, br(1'b0));
        // j, addi
        add(0, 6'b000010, 6'b0, 0, 1, F_OK);
        add(0, 6'b000010, 6'b0, 0, 1, DEC);
        add(0, 6'b000010, 6'b0, 0, 1, JMP);
        add(0, 6'b001000, 6'b0, 0, 1, F_OK);
        add(0, 6'b001000, 6'b0, 0, 1, DEC);
        add(0, 6'b001000, 6'b0, 0, 1, AEX);
        add(0, 6'b001000, 6'b0, 0, 1, AWB);
        // unsupported opcode and funct
        add(0, 6'b000101, 6'b0, 0, 1, F_OK);
        add(0, 6'b000101, 6'b0, 0, 1, DEC_INV);
        add(0, 6'b000000, 6'b000000, 0, 1, F_OK);
        add(0, 6'b000000, 6'b000000, 0, 1, DEC_INV);
        // fetch with memory slow for 3 cycles, then j
        add(0, 6'b000010, 6'b0, 0, 0, F_WAIT);
        add(0, 6'b000010, 6'b0, 0, 0, F_WAIT);
        add(0, 6'b000010, 6'b0, 0, 0, F_WAIT);
        add(0, 6'b000010, 6'b0, 0, 1, F_OK);
        add(0, 6'b000010, 6'b0, 0, 1, DEC);
        add(0, 6'b000010, 6'b0, 0, 1, JMP);
        // lw with a slow data read
        add(0, 6'b100011, 6'b0, 0, 1, F_OK);
        add(0, 6'b100011, 6'b0, 0, 1, DEC);
        add(0, 6'b100011, 6'b0, 0, 1, MADDR);
        add(0, 6'b100011, 6'b0, 0, 0, MRD);
        add(0, 6'b100011, 6'b0, 0, 0, MRD);
        add(0, 6'b100011, 6'b0, 0, 1, MRD);
        add(0, 6'b100011, 6'b0, 0, 1, MWB);
        // sw stalled, reset mid-write, then back in FETCH
        add(0, 6'b101011, 6'b0, 0, 1, F_OK);
        add(0, 6'b101011, 6'b0, 0, 1, DEC);
        add(0, 6'b101011, 6'b0, 0, 1, MADDR);
        add(0, 6'b101011, 6'b0, 0, 0, MWR);
        add(1, 6'b101011, 6'b0, 0, 0, RST);
        add(0, 6'b101011, 6'b0, 0, 0, F_WAIT);

        foreach (vq[i]) begin
            @(negedge clock);
            reset = vq[i].rst; opcode = vq[i].op; funct = vq[i].fn;
            Zero = vq[i].z; MemPronto = vq[i].mp;
            #1;
            a = actual();
            checks++;
            if (a !== vq[i].exp) begin
                errors++;
                $display("FAIL vec%0d: got %h expected %h", i, a, vq[i].exp);
            end
        end

        // cycles per instruction and pulse counts, memory always ready
        run_instr(6'b000000, 6'b100000, cyc, irw, rw, done);
        chk("rtype_done", done, 1); chk("rtype_cpi", cyc, 4);
        chk("rtype_irw", irw, 1);   chk("rtype_rw", rw, 1);
        run_instr(6'b100011, 6'b0, cyc, irw, rw, done);
        chk("lw_done", done, 1); chk("lw_cpi", cyc, 5);
        chk("lw_irw", irw, 1);   chk("lw_rw", rw, 1);
        run_instr(6'b101011, 6'b0, cyc, irw, rw, done);
        chk("sw_done", done, 1); chk("sw_cpi", cyc, 4); chk("sw_rw", rw, 0);
        run_instr(6'b000100, 6'b0, cyc, irw, rw, done);
        chk("beq_done", done, 1); chk("beq_cpi", cyc, 3); chk("beq_rw", rw, 0);
        run_instr(6'b000010, 6'b0, cyc, irw, rw, done);
        chk("j_done", done, 1); chk("j_cpi", cyc, 3);
        run_instr(6'b001000, 6'b0, cyc, irw, rw, done);
        chk("addi_done", done, 1); chk("addi_cpi", cyc, 4); chk("addi_rw", rw, 1);
        run_instr(6'b111111, 6'b0, cyc, irw, rw, done);
        chk("inv_done", done, 1); chk("inv_cpi", cyc, 2); chk("inv_rw", rw, 0);

        // Zero reaches PCEn combinationally within the BRANCH cycle
        @(negedge clock);
        opcode = 6'b000100; funct = 6'b0; Zero = 1'b0; MemPronto = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("br_estado", int'(estado), 8);
        chk("br_pcen_z0", int'(PCEn), 0);
        Zero = 1'b1;
        #1;
        chk("br_pcen_z1", int'(PCEn), 1);
        chk("br_pcsource", int'(PCSource), 1);
        @(posedge clock);
        #1;
        chk("br_back_fetch", int'(estado), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle MIPS32 control unit: the sequencing side of the ALU interface. A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback. It drives `ALUcontrol` and the datapath mux/enable lines, and consumes the ALU's `Zero` flag for branches. It sits between the instruction register and the datapath (PC, register file, memory port, ALU).

## Interface
- No parameters. Encodings are fixed by the shared package.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]; stable from DECODE until the next FETCH.
- `funct` in 6: IR[5:0].
- `Zero` in 1: ALU zero flag.
- `MemPronto` in 1: memory ready; tie high for single-cycle memory.
- `PCEn` out 1: PC write enable; for beq this is already gated with `Zero`.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` out 1, `MemWrite` out 1: memory strobes.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 1: destination register select; 0 = rt, 1 = rd.
- `MemtoReg` out 1: writeback select; 0 = ALUOut, 1 = MDR.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU input A select; 0 = PC, 1 = A.
- `ALUSrcB` out 2: ALU input B select; 00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- `PCSource` out 2: PC source select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUcontrol` out 4: to the ALU. Codes: 0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt, 1100 NOR.
- `invalido` out 1: one-cycle pulse when an unsupported opcode or funct is decoded.
- `estado` out 4: current state, for debug.

## Operation
- Outputs are decoded from the state register only, except for the gating described below.
- Any output not listed for a state is 0.
- States, with their outputs and next-state rule:
  - FETCH (0): MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUcontrol=0010, PCSource=00. IRWrite and PCEn are 1 only when `MemPronto`=1. Stays in FETCH while `MemPronto`=0; otherwise goes to DECODE.
  - DECODE (1): ALUSrcB=11, ALUcontrol=0010 (computes the branch target). Next state by opcode:
    - lw 100011 and sw 101011 → MEM_ADDR
    - R-type 000000 → EXECUTE
    - beq 000100 → BRANCH
    - j 000010 → JUMP
    - addi 001000 → ADDI_EXEC
    - any other opcode → FETCH with `invalido`=1
  - DECODE funct check for R-type: supported functs are add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010. An unsupported funct → FETCH with `invalido`=1.
  - MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, add. Goes to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ (3): MemRead=1, IorD=1. Waits for `MemPronto`, then goes to MEM_WB.
  - MEM_WB (4): RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
  - MEM_WRITE (5): MemWrite=1, IorD=1. Waits for `MemPronto`, then goes to FETCH.
  - EXECUTE (6): ALUSrcA=1, ALUSrcB=00, `ALUcontrol` taken from funct. Goes to R_COMPLETION.
  - R_COMPLETION (7): RegDst=1, RegWrite=1, with `ALUcontrol` held from EXECUTE. Goes to FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUcontrol=0110, PCSource=01, PCEn=`Zero`. Goes to FETCH.
  - JUMP (9): PCSource=10, PCEn=1. Goes to FETCH.
  - ADDI_EXEC (10): ALUSrcA=1, ALUSrcB=10, add. Goes to ADDI_WB.
  - ADDI_WB (11): RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- Unused encodings 12–15 go to FETCH with `invalido`=1, and all enables are 0 in those states.
- While memory is waiting, the strobes stay asserted. `IRWrite` and `PCEn` fire exactly once per fetch.

## Timing
- While `reset`=1, every output is 0, including `ALUcontrol`=0000 and `estado`=0. The first cycle after `reset` falls is FETCH.
- Reset asserted mid-instruction aborts it. No write enable may be asserted in the reset cycle.
- Cycles per instruction with `MemPronto` held high:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Each memory state (FETCH, MEM_READ, MEM_WRITE) adds one cycle for every cycle `MemPronto` is low.
- `invalido` is asserted combinationally in the DECODE cycle, and the next state is FETCH.
- `Zero` is sampled only in BRANCH and is combinational into `PCEn`. There is no registered path.

## Structure
- Package `mips_pkg` holds:
  - state encodings
  - opcode and funct constants
  - `ALUcontrol` codes, which the ALU must use too
- Sub-module `decod_alu`: combinational funct → `ALUcontrol` plus a `funct_valido` flag. It is reused for the DECODE check and for EXECUTE/R_COMPLETION.

## Test plan
- Reset in the middle of MEM_WRITE with `MemPronto`=0 → MemWrite drops to 0 in the same cycle; `estado`=0 next cycle; the following cycle is FETCH.
- Opcode 100011 with `MemPronto`=1 → `estado` goes 0, 1, 2, 3, 4, 0; exactly one IRWrite pulse; exactly one RegWrite pulse, in state 4, with MemtoReg=1.
- R-type with funct 101010, then 100111 → `ALUcontrol`=0111 and then 1100 in EXECUTE and R_COMPLETION; RegDst=1 during the write.
- beq with `Zero`=1 and then with `Zero`=0 → PCEn=1 and then 0 in BRANCH; PCSource=01; 3 cycles each.
- Opcode 000101 and R-type funct 000000 → `invalido` pulses in DECODE; next state FETCH; RegWrite and MemWrite never asserted.
- Fetch with `MemPronto` low for 3 cycles → MemRead=1 for 4 cycles; IRWrite and PCEn high only in the 4th cycle.
